// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: RV32IC fetch-side sequencer.
// Issues one word-aligned instruction-memory read at a time, then splits the
// returned word into 16-bit compressed or 32-bit instructions. A 32-bit
// instruction whose low half sits in the upper half of a word is stitched
// together with the next word. Instructions go downstream one per handshake
// with their PC and a compressed flag. Execute-stage redirects are handled
// here, including discarding the response of a read already in flight.
// All outputs are decoded from registered state only, so there are no
// combinational paths from any input to any output.
//
// Optional build macro: RVC_ALIGN_PERF_EN adds the perf_rvc_count output,
// a wrapping count of accepted compressed instructions.

module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed
`ifdef RVC_ALIGN_PERF_EN
  ,
  output logic [31:0] perf_rvc_count
`endif
);

  // FSM encoding
  localparam logic [1:0] ST_REQ   = 2'd0;  // present a read request
  localparam logic [1:0] ST_WAIT  = 2'd1;  // read accepted, waiting for data
  localparam logic [1:0] ST_ISSUE = 2'd2;  // hand instructions out of wbuf
  localparam logic [1:0] ST_DRAIN = 2'd3;  // drop the response of a stale read

  // A 16-bit parcel whose low two bits are 2'b11 starts a 32-bit instruction.
  function automatic logic is_full_parcel(input logic [15:0] parcel);
    return (parcel[1:0] == 2'b11);
  endfunction

  // Architectural state
  logic [1:0]  state_r;
  logic [31:0] pc_r;          // address of the next instruction to issue
  logic [31:0] fetch_addr_r;  // address of the next word to read
  logic [31:0] wbuf_r;        // last fetched word
  logic [15:0] hbuf_r;        // low half of a straddling 32-bit instruction
  logic        span_r;        // hbuf_r holds a pending low half

  // Next-state values
  logic [1:0]  state_nxt_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] fetch_addr_nxt_s;
  logic [31:0] wbuf_nxt_s;
  logic [15:0] hbuf_nxt_s;
  logic        span_nxt_s;

  // Candidate instruction offered in ISSUE
  logic        cand_valid_s;
  logic [31:0] cand_data_s;
  logic        cand_comp_s;
  logic [31:0] cand_pc_nxt_s;
  logic [1:0]  cand_state_nxt_s;
  logic        span_load_s;   // upper half starts a 32-bit inst: park it
  logic        handshake_s;
  logic        outstanding_s; // a read is (or is becoming) in flight this cycle

  // Select the instruction that wbuf/hbuf/pc present in ISSUE.
  always_comb begin
    cand_valid_s     = 1'b0;
    cand_data_s      = 32'h0000_0000;
    cand_comp_s      = 1'b0;
    cand_pc_nxt_s    = pc_r;
    cand_state_nxt_s = state_r;
    span_load_s      = 1'b0;
    if (state_r == ST_ISSUE) begin
      if (span_r) begin
        // Straddler: high half is the low half of the new word.
        cand_valid_s     = 1'b1;
        cand_data_s      = {wbuf_r[15:0], hbuf_r};
        cand_pc_nxt_s    = pc_r + 32'd4;
        cand_state_nxt_s = ST_ISSUE;
      end else if (!pc_r[1]) begin
        if (!is_full_parcel(wbuf_r[15:0])) begin
          cand_valid_s     = 1'b1;
          cand_data_s      = {16'h0000, wbuf_r[15:0]};
          cand_comp_s      = 1'b1;
          cand_pc_nxt_s    = pc_r + 32'd2;
          cand_state_nxt_s = ST_ISSUE;
        end else begin
          cand_valid_s     = 1'b1;
          cand_data_s      = wbuf_r;
          cand_pc_nxt_s    = pc_r + 32'd4;
          cand_state_nxt_s = ST_REQ;
        end
      end else begin
        if (!is_full_parcel(wbuf_r[31:16])) begin
          cand_valid_s     = 1'b1;
          cand_data_s      = {16'h0000, wbuf_r[31:16]};
          cand_comp_s      = 1'b1;
          cand_pc_nxt_s    = pc_r + 32'd2;
          cand_state_nxt_s = ST_REQ;
        end else begin
          // Nothing to emit yet; the rest lives in the next word.
          span_load_s      = 1'b1;
          cand_state_nxt_s = ST_REQ;
        end
      end
    end else begin
      cand_valid_s = 1'b0;
    end
  end

  assign handshake_s = cand_valid_s & inst_ready;

  // A read is outstanding after this cycle if one is accepted now or one is
  // still awaiting its response.
  assign outstanding_s = ((state_r == ST_REQ)   &  imem_req_ready) |
                         ((state_r == ST_WAIT)  & ~imem_rsp_valid) |
                         ((state_r == ST_DRAIN) & ~imem_rsp_valid);

  // Next-state logic; a redirect overrides everything else.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    fetch_addr_nxt_s = fetch_addr_r;
    wbuf_nxt_s       = wbuf_r;
    hbuf_nxt_s       = hbuf_r;
    span_nxt_s       = span_r;
    case (state_r)
      ST_REQ: begin
        if (imem_req_ready) begin
          fetch_addr_nxt_s = fetch_addr_r + 32'd4;
          state_nxt_s      = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          wbuf_nxt_s  = imem_rsp_data;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        if (span_load_s) begin
          hbuf_nxt_s  = wbuf_r[31:16];
          span_nxt_s  = 1'b1;
          state_nxt_s = cand_state_nxt_s;
        end else if (handshake_s) begin
          pc_nxt_s    = cand_pc_nxt_s;
          span_nxt_s  = 1'b0;
          state_nxt_s = cand_state_nxt_s;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_nxt_s = ST_REQ;  // stale data dropped
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_nxt_s         = redirect_pc & 32'hFFFF_FFFE;
      fetch_addr_nxt_s = redirect_pc & 32'hFFFF_FFFC;
      span_nxt_s       = 1'b0;
      wbuf_nxt_s       = wbuf_r;
      hbuf_nxt_s       = hbuf_r;
      state_nxt_s      = outstanding_s ? ST_DRAIN : ST_REQ;
    end else begin
      span_nxt_s = span_nxt_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC & 32'hFFFF_FFFE;
      fetch_addr_r <= RESET_PC & 32'hFFFF_FFFC;
      wbuf_r       <= 32'h0000_0000;
      hbuf_r       <= 16'h0000;
      span_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      fetch_addr_r <= fetch_addr_nxt_s;
      wbuf_r       <= wbuf_nxt_s;
      hbuf_r       <= hbuf_nxt_s;
      span_r       <= span_nxt_s;
    end
  end

  // Output decode from registered state.
  assign imem_req_valid     = (state_r == ST_REQ);
  assign imem_req_addr      = fetch_addr_r;
  assign inst_valid         = cand_valid_s;
  assign inst_data          = cand_data_s;
  assign inst_pc            = pc_r;
  assign inst_is_compressed = cand_comp_s;

`ifdef RVC_ALIGN_PERF_EN
  logic [31:0] perf_cnt_r;

  // Count accepted compressed instructions; wraps, survives redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_r <= 32'h0000_0000;
    end else if (handshake_s && cand_comp_s) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_rvc_count = perf_cnt_r;
`endif

endmodule
